time_parse_m: RTL and testbench



---
 rtl/time_parse_pkg.sv | 38 +++
 rtl/ascii_digit_m.sv | 16 +
 rtl/time_parse_m.sv | 215 +++++++++++++++++++++
 tb/tb_time_parse_m.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_parse_pkg.sv
// Shared types and constants for the time-string parser.
// Contents: counter/flag types, timestamp tick weights, ASCII codes of the
// framing characters, and the parser state encoding.
package time_parse_pkg;

  localparam int unsigned COUNTER_W   = 17;
  localparam int unsigned COUNTER_MAX = 86399;

  typedef logic [COUNTER_W-1:0] counter_t;

  // Registered one-cycle result pulses; at most one is set at a time.
  typedef struct packed {
    logic set;
    logic alarm;
    logic err;
  } flag_t;

  localparam counter_t MIN_TICK  = counter_t'(60);
  localparam counter_t HOUR_TICK = counter_t'(3600);
  localparam counter_t AMPM_TICK = counter_t'(43200);

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    StIdle,
    StField,
    StDrain,
    StEmit
  } state_e;

endpackage

// File: rtl/ascii_digit_m.sv
// Combinational ASCII decimal digit decoder.
// Ports:
//   char_i     - ASCII byte
//   is_digit_o - byte is '0'..'9'
//   value_o    - numeric value (meaningful only when is_digit_o)
module ascii_digit_m (
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic [3:0] value_o
);

  assign is_digit_o = (char_i >= 8'h30) && (char_i <= 8'h39);
  // '0'..'9' are 0x30..0x39, so the low nibble is the value.
  assign value_o    = char_i[3:0];

endmodule

// File: rtl/time_parse_m.sv
// Parses "<T|A>HH:MM:SS <A|P>M\n" frames into seconds since midnight.
// Ports:
//   clock, reset_n           - clock, async active-low reset
//   char_valid/char_data     - input byte stream
//   char_ready               - byte accepted when char_valid && char_ready
//   set_flag/set_time        - pulse + held value for a new clock time
//   alarm_flag/alarm_time    - pulse + held value for a new alarm time
//   err                      - pulse when a frame is rejected
module time_parse_m
  import time_parse_pkg::*;
#(
  parameter int unsigned COUNTER_MAX = 86399,
  parameter int unsigned COUNTER_W   = 17
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 char_valid,
  input  logic [7:0]           char_data,
  output logic                 char_ready,
  output logic                 set_flag,
  output logic [COUNTER_W-1:0] set_time,
  output logic                 alarm_flag,
  output logic [COUNTER_W-1:0] alarm_time,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [3:0]           pos_q, pos_d;
  logic [COUNTER_W-1:0] acc_q, acc_d;
  logic [3:0]           hour_q, hour_d;
  logic                 tgt_alarm_q, tgt_alarm_d;
  logic                 pm_q, pm_d;
  logic [COUNTER_W-1:0] set_time_q, set_time_d;
  logic [COUNTER_W-1:0] alarm_time_q, alarm_time_d;
  flag_t                flags_q, flags_d;

  logic                 fire, is_cr, is_lf, byte_ok;
  logic                 is_digit;
  logic [3:0]           digit;
  logic [COUNTER_W-1:0] d_ext;
  logic [4:0]           hour_full;
  logic [COUNTER_W:0]   acc_corr;

  ascii_digit_m u_digit (
    .char_i     (char_data),
    .is_digit_o (is_digit),
    .value_o    (digit)
  );

  assign fire      = char_valid && char_ready;
  assign is_cr     = (char_data == CH_CR);
  assign is_lf     = (char_data == CH_LF);
  assign d_ext     = COUNTER_W'(digit);
  assign hour_full = 5'(hour_q) * 5'd10 + 5'(digit);

  // 12 AM/PM carries 12*3600 from the digits; fold it to 0, then add the PM offset.
  always_comb begin
    acc_corr = {1'b0, acc_q};
    if (hour_q == 4'd12) acc_corr = acc_corr - (COUNTER_W+1)'(AMPM_TICK);
    if (pm_q)            acc_corr = acc_corr + (COUNTER_W+1)'(AMPM_TICK);
  end

  // Per-position byte class check and accumulator update.
  always_comb begin
    byte_ok = 1'b0;
    acc_d   = acc_q;
    hour_d  = hour_q;
    pm_d    = pm_q;
    case (pos_q)
      4'd1: begin
        byte_ok = is_digit && (digit <= 4'd1);
        acc_d   = acc_q + d_ext * COUNTER_W'(10 * HOUR_TICK);
        hour_d  = digit;
      end
      4'd2: begin
        byte_ok = is_digit && (hour_full >= 5'd1) && (hour_full <= 5'd12);
        acc_d   = acc_q + d_ext * COUNTER_W'(HOUR_TICK);
        hour_d  = hour_full[3:0];
      end
      4'd3, 4'd6: byte_ok = (char_data == CH_COLON);
      4'd4: begin
        byte_ok = is_digit && (digit <= 4'd5);
        acc_d   = acc_q + d_ext * COUNTER_W'(10 * MIN_TICK);
      end
      4'd5: begin
        byte_ok = is_digit;
        acc_d   = acc_q + d_ext * COUNTER_W'(MIN_TICK);
      end
      4'd7: begin
        byte_ok = is_digit && (digit <= 4'd5);
        acc_d   = acc_q + d_ext * COUNTER_W'(10);
      end
      4'd8: begin
        byte_ok = is_digit;
        acc_d   = acc_q + d_ext;
      end
      4'd9:  byte_ok = (char_data == CH_SPACE);
      4'd10: begin
        byte_ok = (char_data == CH_A) || (char_data == CH_P);
        pm_d    = (char_data == CH_P);
      end
      4'd11: begin
        byte_ok = (char_data == CH_M);
        acc_d   = (acc_corr > (COUNTER_W+1)'(COUNTER_MAX)) ? COUNTER_W'(COUNTER_MAX)
                                                           : acc_corr[COUNTER_W-1:0];
      end
      default: byte_ok = 1'b0;  // position 12 only takes '\n'
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fire && !is_cr && !is_lf) begin
          state_d = (char_data == CH_T || char_data == CH_A) ? StField : StDrain;
        end
      end
      StField: begin
        if (fire && !is_cr) begin
          if (is_lf)         state_d = (pos_q == 4'd12) ? StEmit : StIdle;
          else if (!byte_ok) state_d = StDrain;
        end
      end
      StDrain: if (fire && is_lf) state_d = StIdle;
      StEmit:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; ready is also held low during reset.
  always_comb begin
    char_ready = reset_n && (state_q != StEmit);
  end

  // Datapath and result registers.
  always_comb begin
    pos_d        = pos_q;
    tgt_alarm_d  = tgt_alarm_q;
    set_time_d   = set_time_q;
    alarm_time_d = alarm_time_q;
    flags_d      = '0;
    if (fire && !is_cr) begin
      unique case (state_q)
        StIdle: begin
          if (char_data == CH_T || char_data == CH_A) begin
            pos_d       = 4'd1;
            tgt_alarm_d = (char_data == CH_A);
          end
        end
        StField: begin
          if (is_lf) begin
            if (pos_q == 4'd12) begin
              if (tgt_alarm_q) begin
                alarm_time_d  = acc_q;
                flags_d.alarm = 1'b1;
              end else begin
                set_time_d    = acc_q;
                flags_d.set   = 1'b1;
              end
            end else begin
              flags_d.err = 1'b1;
            end
          end else if (byte_ok) begin
            pos_d = pos_q + 4'd1;
          end
        end
        StDrain: if (is_lf) flags_d.err = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q        <= '0;
      acc_q        <= '0;
      hour_q       <= '0;
      tgt_alarm_q  <= 1'b0;
      pm_q         <= 1'b0;
      set_time_q   <= '0;
      alarm_time_q <= '0;
      flags_q      <= '0;
    end else begin
      pos_q        <= pos_d;
      tgt_alarm_q  <= tgt_alarm_d;
      set_time_q   <= set_time_d;
      alarm_time_q <= alarm_time_d;
      flags_q      <= flags_d;
      if (fire && state_q == StIdle) begin
        acc_q  <= '0;
        hour_q <= '0;
        pm_q   <= 1'b0;
      end else if (fire && state_q == StField && !is_cr && !is_lf && byte_ok) begin
        acc_q  <= acc_d;
        hour_q <= hour_d;
        pm_q   <= pm_d;
      end
    end
  end

  assign set_flag   = flags_q.set;
  assign alarm_flag = flags_q.alarm;
  assign err        = flags_q.err;
  assign set_time   = set_time_q;
  assign alarm_time = alarm_time_q;

endmodule

// File: tb/tb_time_parse_m.sv
module tb_time_parse_m;

  typedef logic [7:0] u8;
  typedef struct {
    int kind;  // 1 set, 2 alarm, 3 err
    int val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        set_flag, alarm_flag, err;
  logic [16:0] set_time, alarm_time;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  u8    line_q[$];
  int   model_set = 0;
  int   model_alarm = 0;
  int   exp_emits = 0;
  int   ready_low = 0;
  logic nl_hs;

  always #5 clock = ~clock;

  time_parse_m #(
    .COUNTER_MAX (86399),
    .COUNTER_W   (17)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .set_flag   (set_flag),
    .set_time   (set_time),
    .alarm_flag (alarm_flag),
    .alarm_time (alarm_time),
    .err        (err)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic bit is_dig(input u8 c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic int dv(input u8 c);
    return int'(c) - 48;
  endfunction

  function automatic u8 dig(input int d);
    return u8'(48 + d);
  endfunction

  // Reference: a whole line (CR stripped) is either a well-formed 12-char time or an error.
  task automatic model_newline();
    int n, h, m, s, kind, val;
    bit ok;
    n   = line_q.size();
    val = 0;
    if (n == 0) return;
    ok = (n == 12);
    if (ok) begin
      ok = (line_q[0] == "T" || line_q[0] == "A") && is_dig(line_q[1]) && is_dig(line_q[2]) &&
           line_q[3] == ":" && is_dig(line_q[4]) && is_dig(line_q[5]) && line_q[6] == ":" &&
           is_dig(line_q[7]) && is_dig(line_q[8]) && line_q[9] == " " &&
           (line_q[10] == "A" || line_q[10] == "P") && line_q[11] == "M";
    end
    if (ok) begin
      h  = dv(line_q[1]) * 10 + dv(line_q[2]);
      m  = dv(line_q[4]) * 10 + dv(line_q[5]);
      s  = dv(line_q[7]) * 10 + dv(line_q[8]);
      ok = (h >= 1) && (h <= 12) && (m < 60) && (s < 60);
      if (ok) val = ((h % 12) + ((line_q[10] == "P") ? 12 : 0)) * 3600 + m * 60 + s;
    end
    if (ok) begin
      kind = (line_q[0] == "T") ? 1 : 2;
      exp_emits++;
    end else begin
      kind = 3;
    end
    exp_q.push_back('{kind, val});
    line_q.delete();
  endtask

  task automatic send_byte(input u8 b);
    int waitc = 0;
    if (b == 8'h0A)      model_newline();
    else if (b != 8'h0D) line_q.push_back(b);
    char_valid = 1'b1;
    char_data  = b;
    forever begin
      @(negedge clock);
      if (char_ready) break;
      waitc++;
      if (waitc > 50) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(u8'(s[i]));
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain();
    char_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      check("pending_events", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(char_ready), 0);
    check({tag, "_set_time"}, int'(set_time), 0);
    check({tag, "_alarm_time"}, int'(alarm_time), 0);
    check({tag, "_flags"}, int'({set_flag, alarm_flag, err}), 0);
  endtask

  task automatic send_random_frame();
    u8  fr[$];
    int kind, h, m, s;
    kind = int'($urandom_range(0, 9));
    h    = int'($urandom_range(1, 12));
    m    = int'($urandom_range(0, 59));
    s    = int'($urandom_range(0, 59));
    if (kind == 8) begin
      h = int'($urandom_range(0, 19));
      m = int'($urandom_range(0, 69));
      s = int'($urandom_range(0, 69));
    end
    fr.push_back(($urandom_range(0, 1) != 0) ? u8'("T") : u8'("A"));
    fr.push_back(dig(h / 10));
    fr.push_back(dig(h % 10));
    fr.push_back(":");
    fr.push_back(dig(m / 10));
    fr.push_back(dig(m % 10));
    fr.push_back(":");
    fr.push_back(dig(s / 10));
    fr.push_back(dig(s % 10));
    fr.push_back(" ");
    fr.push_back(($urandom_range(0, 1) != 0) ? u8'("P") : u8'("A"));
    fr.push_back("M");
    if (kind == 6) fr[$urandom_range(0, 11)] = u8'($urandom_range(32, 126));
    if (kind == 7) begin
      int n = int'($urandom_range(0, 11));
      while (fr.size() > n) void'(fr.pop_back());
    end
    if (kind == 9) fr.push_back(u8'($urandom_range(32, 126)));
    fr.push_back(8'h0A);
    foreach (fr[i]) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      if ($urandom_range(0, 7) == 0) send_byte(8'h0D);
      send_byte(fr[i]);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) nl_hs <= 1'b0;
    else          nl_hs <= char_valid && char_ready && (char_data == 8'h0A);
  end

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (!char_ready) ready_low++;
      if (set_flag || alarm_flag || err) begin
        exp_t e;
        int   got_kind;
        check("one_pulse", int'(set_flag) + int'(alarm_flag) + int'(err), 1);
        check("pulse_after_lf", int'(nl_hs), 1);
        got_kind = err ? 3 : (set_flag ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", got_kind, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", got_kind, e.kind);
          if (e.kind == 1) model_set = e.val;
          if (e.kind == 2) model_alarm = e.val;
          check("set_time", int'(set_time), model_set);
          check("alarm_time", int'(alarm_time), model_alarm);
        end
      end
    end
  end

  initial begin
    int r0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", int'(char_ready), 1);
    @(posedge clock);
    #1;

    send_str("T12:00:00 AM\n");
    send_str("T11:59:59 PM\n");
    send_str("A07:30:15 AM\n");
    send_str("T13:00:00 PM\n");
    send_str("T12:00:01 PM\n");
    send_str("\n");
    wait_drain();

    // Reset in the middle of a frame.
    send_str("T05:3");
    idle(1);
    reset_n = 1'b0;
    #2;
    check_all_zero("mid_reset");
    line_q.delete();
    model_set   = 0;
    model_alarm = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_str("0:00 AM\n");
    send_str("T05:30:00 AM\n");
    wait_drain();

    // Streaming with CR before each LF: one bubble per good frame.
    r0 = ready_low;
    send_str("T03:04:05 PM\r\nA11:22:33 AM\r\n");
    wait_drain();
    check("stream_bubbles", ready_low - r0, 2);

    for (int i = 0; i < 150; i++) send_random_frame();
    wait_drain();
    check("bubble_total", ready_low, exp_emits);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
